// File: rtl/exec_datapath.sv
// rtl/exec_datapath.sv - execute-side datapath: decoder, 8-bit ALU and 256x8 data memory
// Registered writeback/branch outcome one cycle after exec_en; memory cleared on reset.
module exec_datapath (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       exec_en,
    input  logic [7:0] instruction,
    input  logic [7:0] pc,
    input  logic [7:0] reg_data_0,
    input  logic [7:0] reg_data_1,
    output logic [1:0] reg_addr_0,
    output logic [1:0] reg_addr_1,
    output logic [1:0] reg_addr_w,
    output logic       reg_w_en,
    output logic [7:0] reg_data_w,
    output logic       jump,
    output logic       overflow,
    output logic       done
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_BNE  = 4'hD;
    localparam logic [3:0] OP_J    = 4'hE;
    localparam logic [3:0] OP_JAL  = 4'hF;

    logic [3:0] opcode;
    logic [1:0] field_a;
    logic [1:0] field_b;
    logic [7:0] sum;
    logic [7:0] diff;
    logic [7:0] addi_sum;
    logic [7:0] mem_rdata;

    logic [7:0] mem_q [256];

    logic [1:0] reg_addr_w_q, reg_addr_w_d;
    logic       reg_w_en_q, reg_w_en_d;
    logic [7:0] reg_data_w_q, reg_data_w_d;
    logic       jump_q, jump_d;
    logic       overflow_q, overflow_d;
    logic       done_q;

    assign opcode     = instruction[7:4];
    assign field_a    = instruction[3:2];
    assign field_b    = instruction[1:0];
    assign reg_addr_0 = field_a;
    assign reg_addr_1 = field_b;

    assign sum       = reg_data_0 + reg_data_1;
    assign diff      = reg_data_0 - reg_data_1;
    assign addi_sum  = reg_data_0 + {6'b0, field_b};
    assign mem_rdata = mem_q[reg_data_0];

    always_comb begin
        reg_data_w_d = 8'h00;
        reg_w_en_d   = 1'b0;
        reg_addr_w_d = field_a;
        jump_d       = 1'b0;
        overflow_d   = 1'b0;
        case (opcode)
            OP_ADD: begin
                reg_data_w_d = sum;
                reg_w_en_d   = 1'b1;
                overflow_d   = (reg_data_0[7] == reg_data_1[7]) && (sum[7] != reg_data_0[7]);
            end
            OP_SUB: begin
                reg_data_w_d = diff;
                reg_w_en_d   = 1'b1;
                overflow_d   = (reg_data_0[7] != reg_data_1[7]) && (diff[7] != reg_data_0[7]);
            end
            OP_AND: begin
                reg_data_w_d = reg_data_0 & reg_data_1;
                reg_w_en_d   = 1'b1;
            end
            OP_OR: begin
                reg_data_w_d = reg_data_0 | reg_data_1;
                reg_w_en_d   = 1'b1;
            end
            OP_XOR: begin
                reg_data_w_d = reg_data_0 ^ reg_data_1;
                reg_w_en_d   = 1'b1;
            end
            OP_NOR: begin
                reg_data_w_d = ~(reg_data_0 | reg_data_1);
                reg_w_en_d   = 1'b1;
            end
            OP_SLL: begin
                reg_data_w_d = reg_data_0 << reg_data_1[2:0];
                reg_w_en_d   = 1'b1;
            end
            OP_SRL: begin
                reg_data_w_d = reg_data_0 >> reg_data_1[2:0];
                reg_w_en_d   = 1'b1;
            end
            OP_SLT: begin
                reg_data_w_d = {7'b0, $signed(reg_data_0) < $signed(reg_data_1)};
                reg_w_en_d   = 1'b1;
            end
            OP_ADDI: begin
                // Immediate is non-negative, so only a positive operand can overflow.
                reg_data_w_d = addi_sum;
                reg_w_en_d   = 1'b1;
                overflow_d   = !reg_data_0[7] && addi_sum[7];
            end
            OP_LW: begin
                reg_data_w_d = mem_rdata;
                reg_w_en_d   = 1'b1;
                reg_addr_w_d = field_b;
            end
            OP_SW: ;
            OP_BEQ: jump_d = (reg_data_0 == reg_data_1);
            OP_BNE: jump_d = (reg_data_0 != reg_data_1);
            OP_J:   jump_d = 1'b1;
            OP_JAL: begin
                reg_data_w_d = pc + 8'd1;
                reg_w_en_d   = 1'b1;
                reg_addr_w_d = 2'd3;
                jump_d       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (exec_en && (opcode == OP_SW)) begin
            mem_q[reg_data_0] <= reg_data_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_addr_w_q <= 2'd0;
            reg_w_en_q   <= 1'b0;
            reg_data_w_q <= 8'h00;
            jump_q       <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= exec_en;
            if (exec_en) begin
                reg_addr_w_q <= reg_addr_w_d;
                reg_w_en_q   <= reg_w_en_d;
                reg_data_w_q <= reg_data_w_d;
                jump_q       <= jump_d;
                overflow_q   <= overflow_d;
            end
        end
    end

    assign reg_addr_w = reg_addr_w_q;
    assign reg_w_en   = reg_w_en_q;
    assign reg_data_w = reg_data_w_q;
    assign jump       = jump_q;
    assign overflow   = overflow_q;
    assign done       = done_q;

endmodule

// File: tb/tb_exec_datapath.sv
// tb/tb_exec_datapath.sv - self-checking bench for exec_datapath
// Directed scenarios plus randomized back-to-back traffic against an arithmetic reference model.
module tb_exec_datapath;

    logic       clk;
    logic       rst_n;
    logic       exec_en;
    logic [7:0] instruction;
    logic [7:0] pc;
    logic [7:0] reg_data_0;
    logic [7:0] reg_data_1;
    logic [1:0] reg_addr_0;
    logic [1:0] reg_addr_1;
    logic [1:0] reg_addr_w;
    logic       reg_w_en;
    logic [7:0] reg_data_w;
    logic       jump;
    logic       overflow;
    logic       done;

    int checks   = 0;
    int failures = 0;

    int mem_m [256];

    exec_datapath dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exec_en     (exec_en),
        .instruction (instruction),
        .pc          (pc),
        .reg_data_0  (reg_data_0),
        .reg_data_1  (reg_data_1),
        .reg_addr_0  (reg_addr_0),
        .reg_addr_1  (reg_addr_1),
        .reg_addr_w  (reg_addr_w),
        .reg_w_en    (reg_w_en),
        .reg_data_w  (reg_data_w),
        .jump        (jump),
        .overflow    (overflow),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sx(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    // Reference: value-level semantics of each opcode; also applies sw to the memory model.
    function automatic void model(input int op, input int fa, input int fb, input int pcv,
                                  input int ra, input int rb,
                                  output int data, output int wen, output int wa,
                                  output int jmp, output int ovf);
        int s;
        data = 0; wen = 1; wa = fa; jmp = 0; ovf = 0;
        case (op)
            0:  begin data = (ra + rb) % 256; s = sx(ra) + sx(rb); ovf = (s > 127 || s < -128); end
            1:  begin data = (ra - rb + 256) % 256; s = sx(ra) - sx(rb); ovf = (s > 127 || s < -128); end
            2:  data = ra & rb;
            3:  data = ra | rb;
            4:  data = ra ^ rb;
            5:  data = 255 - (ra | rb);
            6:  data = (ra * (1 << (rb % 8))) % 256;
            7:  data = ra / (1 << (rb % 8));
            8:  data = (sx(ra) < sx(rb)) ? 1 : 0;
            9:  begin data = (ra + fb) % 256; s = sx(ra) + fb; ovf = (s > 127); end
            10: begin data = mem_m[ra]; wa = fb; end
            11: begin wen = 0; mem_m[ra] = rb; end
            12: begin wen = 0; jmp = (ra == rb); end
            13: begin wen = 0; jmp = (ra != rb); end
            14: begin wen = 0; jmp = 1; end
            default: begin data = (pcv + 1) % 256; wa = 3; jmp = 1; end
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [7:0] pcv, input logic [7:0] ra, input logic [7:0] rb);
        instruction = {op, fa, fb};
        pc          = pcv;
        reg_data_0  = ra;
        reg_data_1  = rb;
        exec_en     = 1'b1;
        @(posedge clk);
        #1 exec_en  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) mem_m[i] = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        exec_en = 1'b0; instruction = 8'h00; pc = 8'h00; reg_data_0 = 8'h00; reg_data_1 = 8'h00;
        do_reset();
        checks++;
        if ({reg_addr_w, reg_w_en, reg_data_w, jump, overflow, done} !== 14'h0) begin
            failures++;
            $display("FAIL reset_outputs: got addr_w=%0d w_en=%0b data_w=%02h jump=%0b ovf=%0b done=%0b, want all 0",
                     reg_addr_w, reg_w_en, reg_data_w, jump, overflow, done);
        end
        drive(4'hA, 2'd0, 2'd1, 8'h00, 8'h55, 8'h00);
        checks++;
        if (reg_data_w !== 8'h00 || reg_w_en !== 1'b1) begin
            failures++;
            $display("FAIL reset_lw55: got data_w=%02h w_en=%0b, want 00/1", reg_data_w, reg_w_en);
        end
    endtask

    task automatic test_add_overflow();
        drive(4'h0, 2'd1, 2'd2, 8'h00, 8'h7F, 8'h01);
        checks++;
        if (reg_data_w !== 8'h80 || overflow !== 1'b1 || reg_w_en !== 1'b1 ||
            reg_addr_w !== 2'd1 || done !== 1'b1) begin
            failures++;
            $display("FAIL add_overflow: got data_w=%02h ovf=%0b w_en=%0b addr_w=%0d done=%0b, want 80/1/1/1/1",
                     reg_data_w, overflow, reg_w_en, reg_addr_w, done);
        end
    endtask

    task automatic test_sub_wrap();
        drive(4'h1, 2'd0, 2'd3, 8'h00, 8'h00, 8'h01);
        checks++;
        if (reg_data_w !== 8'hFF || overflow !== 1'b0) begin
            failures++;
            $display("FAIL sub_wrap: got data_w=%02h ovf=%0b, want FF/0", reg_data_w, overflow);
        end
    endtask

    task automatic test_store_load();
        drive(4'hB, 2'd1, 2'd2, 8'h00, 8'h10, 8'hA5);
        checks++;
        if (reg_w_en !== 1'b0 || reg_data_w !== 8'h00) begin
            failures++;
            $display("FAIL sw_no_write: got w_en=%0b data_w=%02h, want 0/00", reg_w_en, reg_data_w);
        end
        drive(4'hA, 2'd1, 2'd2, 8'h00, 8'h10, 8'h00);
        checks++;
        if (reg_data_w !== 8'hA5 || reg_addr_w !== 2'd2 || reg_w_en !== 1'b1) begin
            failures++;
            $display("FAIL lw_after_sw: got data_w=%02h addr_w=%0d w_en=%0b, want A5/2/1",
                     reg_data_w, reg_addr_w, reg_w_en);
        end
    endtask

    task automatic test_branches();
        drive(4'hC, 2'd1, 2'd2, 8'h00, 8'h33, 8'h33);
        checks++;
        if (jump !== 1'b1 || reg_w_en !== 1'b0) begin
            failures++;
            $display("FAIL beq_taken: got jump=%0b w_en=%0b, want 1/0", jump, reg_w_en);
        end
        drive(4'hD, 2'd1, 2'd2, 8'h00, 8'h33, 8'h33);
        checks++;
        if (jump !== 1'b0 || reg_w_en !== 1'b0) begin
            failures++;
            $display("FAIL bne_not_taken: got jump=%0b w_en=%0b, want 0/0", jump, reg_w_en);
        end
    endtask

    task automatic test_jal_shift();
        drive(4'hF, 2'd0, 2'd0, 8'hFF, 8'h12, 8'h34);
        checks++;
        if (reg_data_w !== 8'h00 || reg_addr_w !== 2'd3 || jump !== 1'b1 || reg_w_en !== 1'b1) begin
            failures++;
            $display("FAIL jal_wrap: got data_w=%02h addr_w=%0d jump=%0b w_en=%0b, want 00/3/1/1",
                     reg_data_w, reg_addr_w, jump, reg_w_en);
        end
        drive(4'h6, 2'd2, 2'd1, 8'h00, 8'h81, 8'h09);
        checks++;
        if (reg_data_w !== 8'h02 || jump !== 1'b0) begin
            failures++;
            $display("FAIL sll_mask: got data_w=%02h jump=%0b, want 02/0", reg_data_w, jump);
        end
    endtask

    task automatic test_hold();
        drive(4'h2, 2'd3, 2'd1, 8'h00, 8'hF0, 8'h3C);
        repeat (2) @(negedge clk);
        checks++;
        if (reg_data_w !== 8'h30 || reg_addr_w !== 2'd3 || reg_w_en !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL hold_idle: got data_w=%02h addr_w=%0d w_en=%0b done=%0b, want 30/3/1/0",
                     reg_data_w, reg_addr_w, reg_w_en, done);
        end
    endtask

    task automatic test_addr_decode();
        for (int i = 0; i < 16; i++) begin
            instruction = 8'($urandom);
            #1;
            checks++;
            if (reg_addr_0 !== instruction[3:2] || reg_addr_1 !== instruction[1:0]) begin
                failures++;
                $display("FAIL addr_decode: ins=%02h got a0=%0d a1=%0d", instruction, reg_addr_0, reg_addr_1);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_clears_mem();
        drive(4'hB, 2'd0, 2'd1, 8'h00, 8'h55, 8'h9C);
        mem_m[8'h55] = 8'h9C;
        drive(4'hA, 2'd0, 2'd1, 8'h00, 8'h55, 8'h00);
        checks++;
        if (reg_data_w !== 8'h9C) begin
            failures++;
            $display("FAIL pre_reset_lw: got data_w=%02h, want 9C", reg_data_w);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) mem_m[i] = 0;
        instruction = 8'hB1; reg_data_0 = 8'h66; reg_data_1 = 8'h11; exec_en = 1'b1;
        @(posedge clk);
        #1 exec_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({reg_addr_w, reg_w_en, reg_data_w, jump, overflow, done} !== 14'h0) begin
            failures++;
            $display("FAIL reset_again: got data_w=%02h w_en=%0b done=%0b, want 0", reg_data_w, reg_w_en, done);
        end
        drive(4'hA, 2'd0, 2'd1, 8'h00, 8'h55, 8'h00);
        checks++;
        if (reg_data_w !== 8'h00) begin
            failures++;
            $display("FAIL reset_clears_mem: got data_w=%02h, want 00", reg_data_w);
        end
        drive(4'hA, 2'd0, 2'd1, 8'h00, 8'h66, 8'h00);
        checks++;
        if (reg_data_w !== 8'h00) begin
            failures++;
            $display("FAIL reset_aborts_sw: got data_w=%02h, want 00", reg_data_w);
        end
    endtask

    task automatic test_back_to_back_random();
        int op, fa, fb, pcv, ra, rb;
        int e_data, e_wen, e_wa, e_jmp, e_ovf;
        for (int n = 0; n < 300; n++) begin
            op  = $urandom_range(0, 15);
            fa  = $urandom_range(0, 3);
            fb  = $urandom_range(0, 3);
            pcv = $urandom_range(0, 255);
            ra  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
            rb  = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) rb = ra;
            instruction = {4'(op), 2'(fa), 2'(fb)};
            pc          = 8'(pcv);
            reg_data_0  = 8'(ra);
            reg_data_1  = 8'(rb);
            exec_en     = 1'b1;
            model(op, fa, fb, pcv, ra, rb, e_data, e_wen, e_wa, e_jmp, e_ovf);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (reg_data_w !== 8'(e_data) || reg_w_en !== 1'(e_wen) || reg_addr_w !== 2'(e_wa) ||
                jump !== 1'(e_jmp) || overflow !== 1'(e_ovf) || done !== 1'b1) begin
                failures++;
                $display("FAIL random[%0d] op=%0d ra=%02h rb=%02h: got data=%02h wen=%0b wa=%0d j=%0b ovf=%0b done=%0b, want %02h/%0d/%0d/%0d/%0d/1",
                         n, op, ra, rb, reg_data_w, reg_w_en, reg_addr_w, jump, overflow, done,
                         e_data, e_wen, e_wa, e_jmp, e_ovf);
            end
        end
        exec_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_add_overflow();
        test_sub_wrap();
        test_store_load();
        mem_m[8'h10] = 8'hA5;
        test_branches();
        test_jal_shift();
        test_hold();
        test_addr_decode();
        test_reset_clears_mem();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
